led7seg_scan_ctrl: RTL and testbench
====================================

// Module: led7seg_scan_ctrl
// PURPOSE
//   Multiplexed-display scheduler for hc595_driver. Cycles through NUM_DIGITS 7-seg digits.
//   Converts each hex digit to a segment pattern and builds a 16-bit frame {seg, dig_sel}.
//   Hands the frame to the shift-register driver via its en_input/RDY handshake.
//   Sits between the counter/BCD logic and hc595_driver (N=16) at top level.
// PARAMETERS
//   CLK_FREQ    100_000_000  input clock frequency, Hz
//   SCAN_FREQ   1000         per-digit refresh rate, Hz (tick period = CLK_FREQ/SCAN_FREQ cycles)
//   NUM_DIGITS  8            digits scanned, 1..8
// PORTS
//   clk        in   1               system clock, all logic on posedge
//   rst        in   1               reset, asynchronous, active-high
//   digits_in  in   4*NUM_DIGITS    hex nibble per digit; digit 0 = bits[3:0] = rightmost
//   dp_in      in   NUM_DIGITS      decimal point per digit, 1 = lit
//   blank      in   1               1 = all segments off (frames still sent)
//   hc_rdy     in   1               driver RDY; 1 = idle, ready for a frame
//   hc_en      out  1               one-cycle pulse to driver en_input
//   hc_data    out  16              frame to driver data_in: [15:8] seg, [7:0] dig_sel
//   digit_idx  out  3               digit currently shown
//   overrun    out  1               sticky: scan tick arrived while a frame was still pending
// BEHAVIOUR
//   Frame format
//     seg active-low: bit7 = dp, bits6:0 = g..a.
//     dig_sel one-hot active-high: bit[digit_idx].
//     Hex decode 0-F, standard glyphs (b, d lowercase).
//   Tick counter
//     Free-running, wraps at CLK_FREQ/SCAN_FREQ-1.
//     Asserts tick for one cycle on wrap.
//   FSM states: IDLE, LOAD, GUARD, WAIT_DONE
//     IDLE      -> LOAD on tick.
//     LOAD      if hc_rdy: latch frame of digit_idx into hc_data, hc_en=1 for one cycle, -> GUARD;
//               else stay in LOAD.
//     GUARD     one cycle; hc_rdy ignored (driver may drop RDY late). -> WAIT_DONE.
//     WAIT_DONE on hc_rdy=1: digit_idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, -> IDLE.
//   Latency
//     Tick in IDLE with hc_rdy=1: hc_en high 2 cycles after the tick cycle.
//   hc_data
//     Holds stable from the hc_en cycle until the next LOAD.
//     Inputs are sampled only in LOAD.
//   Overrun
//     Tick while state != IDLE sets overrun (sticky until rst); the tick is dropped.
//     Tick coincident with the WAIT_DONE->IDLE transition counts as overrun.
//   Reset (asynchronous, any state, including mid-frame)
//     hc_en=0, hc_data=16'hFF00, digit_idx=0, overrun=0, state=IDLE, tick counter=0.
//   blank=1: seg=8'hFF (dp also off); dig_sel still one-hot.
// CONFIGURATION
//   LED7SEG_LZB_EN defined: leading-zero blanking.
//     Digit i is blanked (seg=8'hFF) when its nibble and all higher nibbles are 0 and i != 0.
//     dp_in[i]=1 cancels blanking for digit i and all lower digits.
//   LED7SEG_LZB_EN undefined: every digit is displayed, zeros included.
// STRUCTURE
//   led7seg_pkg: shared by counter top and other display blocks.
//     SEG_* localparam glyph table.
//     FSM state encodings (2-bit).
//     FRAME_W = 16, blank constant 8'hFF.
//   Sub-module hex_to_seg7: combinational nibble + dp -> active-low seg byte.
//   Tick generator stays inline (counter + compare).
// TESTING  (CLK_FREQ=1000, SCAN_FREQ=100 -> tick every 10 clk; driver model: RDY low 20 clk after en)
//   digits_in=32'h1234_5678, dp_in=0, blank=0
//     -> first frame 16'h8001 (glyph '8' = 8'h80).
//     -> digit_idx 0..7 in order; frame 8 has dig_sel=8'h80, seg=8'hF9 ('1').
//   Model RDY held low 25 clk
//     -> LOAD waits; hc_en asserted exactly one cycle after RDY rises.
//     -> next tick during wait sets overrun=1.
//   rst pulse while in WAIT_DONE
//     -> same-cycle hc_en=0, hc_data=16'hFF00, digit_idx=0.
//     -> scan restarts at digit 0 after release.
//   blank=1
//     -> every frame has seg=8'hFF with one-hot dig_sel.
//   LED7SEG_LZB_EN, digits_in=32'h0000_0120
//     -> digits 3..7 seg=8'hFF; digit 0 shows '0' (8'hC0).
//   NUM_DIGITS=4
//     -> digit_idx wraps 3->0; dig_sel only in bits[3:0].

Source files
------------

// File: rtl/led7seg_pkg.sv
// Shared display constants: glyph table, frame width, blank pattern and scan FSM encoding.
// Segment glyphs are active-low, bit order g..a.
package led7seg_pkg;

  localparam int FRAME_W = 16;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_GUARD     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } scan_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble + decimal point -> active-low segment byte {dp, g..a}.
// Zero latency; no handshake.
module hex_to_seg7
  import led7seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, hex_glyph(nib_i)};

endmodule

// File: rtl/led7seg_scan_ctrl.sv
// Multiplexed 7-seg scan scheduler feeding a 16-bit shift-register driver; hc_en lands 2 cycles after a tick.
// Waits in LOAD while the driver is busy; ticks arriving mid-frame are dropped and flagged. Optional LED7SEG_LZB_EN.
module led7seg_scan_ctrl
  import led7seg_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SCAN_FREQ  = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank,
  input  logic                      hc_rdy,
  output logic                      hc_en,
  output logic [FRAME_W-1:0]        hc_data,
  output logic [2:0]                digit_idx,
  output logic                      overrun
);

  localparam int TICK_DIV = CLK_FREQ / SCAN_FREQ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  scan_state_e        state_q;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic               hc_en_q;
  logic [FRAME_W-1:0] hc_data_q, frame_d;
  logic [2:0]         idx_q, idx_d;
  logic               overrun_q;

  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic [7:0]         seg_raw;
  logic [7:0]         dig_sel;
  logic               seg_off;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign idx_d      = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_nib = digits_in[4*i +: 4];
        cur_dp  = dp_in[i];
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i (cur_nib),
    .dp_i  (cur_dp),
    .seg_o (seg_raw)
  );

`ifdef LED7SEG_LZB_EN
  // Blank only while this digit and everything above it is zero with no dp lit.
  logic lead_zero;
  always_comb begin
    lead_zero = (idx_q != 3'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) >= idx_q && (digits_in[4*i +: 4] != 4'h0 || dp_in[i])) begin
        lead_zero = 1'b0;
      end
    end
  end
  assign seg_off = blank | lead_zero;
`else
  assign seg_off = blank;
`endif

  assign dig_sel = 8'b1 << idx_q;
  assign frame_d = {(seg_off ? SEG_BLANK : seg_raw), dig_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      hc_en_q    <= 1'b0;
      hc_data_q  <= {SEG_BLANK, 8'h00};
      idx_q      <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hc_en_q    <= 1'b0;
      if (tick && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (tick) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hc_rdy) begin
            hc_data_q <= frame_d;
            hc_en_q   <= 1'b1;
            state_q   <= ST_GUARD;
          end
        end
        // Driver may still report RDY in the cycle after en; do not trust it yet.
        ST_GUARD: begin
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (hc_rdy) begin
            idx_q   <= idx_d;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hc_en     = hc_en_q;
  assign hc_data   = hc_data_q;
  assign digit_idx = idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Bench for led7seg_scan_ctrl: randomized digits checked against a frame model, plus
// directed overrun, stalled-LOAD, mid-frame reset and blanking steps.
module tb_led7seg_scan_ctrl;

  localparam int N = 8;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [31:0] PAT [4] = '{32'h0000_0120, 32'h0000_0000, 32'h0000_0001, 32'h00AB_CDEF};

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   digits_in;
  logic [7:0]    dp_in;
  logic          blank;
  logic          hc_rdy;
  logic          hc_en;
  logic [15:0]   hc_data;
  logic [2:0]    digit_idx;
  logic          overrun;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic        hold = 1'b0;
  int          dly_lo = 1;
  int          dly_hi = 4;
  logic        expect_no_ovr = 1'b1;

  int          frames = 0;
  logic [15:0] last_frame = 16'hFF00;
  logic        prev_en = 1'b0;
  logic [31:0] sh_dig = '0;
  logic [7:0]  sh_dp = '0;
  logic        sh_bl = 1'b0;

  always #5 clk = ~clk;

  led7seg_scan_ctrl #(
    .CLK_FREQ   (1000),
    .SCAN_FREQ  (100),
    .NUM_DIGITS (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank     (blank),
    .hc_rdy    (hc_rdy),
    .hc_en     (hc_en),
    .hc_data   (hc_data),
    .digit_idx (digit_idx),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_frame(input int idx, input logic [31:0] dg,
                                              input logic [7:0] dp, input logic bl);
    logic [7:0] seg;
    logic [7:0] sel;
    seg = {~dp[idx], GLYPH[dg[idx*4 +: 4]]};
    if (bl) seg = 8'hFF;
`ifdef LED7SEG_LZB_EN
    begin
      bit lead;
      lead = (idx != 0);
      for (int j = idx; j < N; j++)
        if (dg[j*4 +: 4] != 4'h0 || dp[j]) lead = 0;
      if (lead) seg = 8'hFF;
    end
`endif
    sel = 8'h00;
    sel[idx] = 1'b1;
    return {seg, sel};
  endfunction

  // Driver model: RDY drops when en is seen and returns after a random busy time.
  initial begin
    int busy;
    busy = 0;
    hc_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        hc_rdy = 1'b1;
        busy = 0;
      end else if (hold) begin
        hc_rdy = 1'b0;
        busy = 0;
      end else if (hc_en) begin
        hc_rdy = 1'b0;
        busy = $urandom_range(dly_hi, dly_lo);
      end else if (busy > 1) begin
        busy--;
      end else begin
        busy = 0;
        hc_rdy = 1'b1;
      end
    end
  end

  // Frame monitor: every en carries the frame for the next digit in scan order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        frames = 0;
        last_frame = 16'hFF00;
      end else if (hc_en) begin
        chk("en_one_cycle", 32'(prev_en), 32'd0);
        chk("frame", 32'(hc_data), 32'(model_frame(frames % N, sh_dig, sh_dp, sh_bl)));
        chk("digit_idx", 32'(digit_idx), 32'(frames % N));
        if (expect_no_ovr) chk("no_overrun", 32'(overrun), 32'd0);
        frames++;
        last_frame = hc_data;
      end else begin
        chk("data_stable", 32'(hc_data), 32'(last_frame));
      end
      prev_en = hc_en;
      sh_dig = digits_in;
      sh_dp = dp_in;
      sh_bl = blank;
    end
  end

  task automatic wait_frames(input int n);
    int seen;
    int budget;
    seen = 0;
    budget = n * 60 + 100;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (hc_en) seen++;
    end
    if (seen < n) chk("frame_timeout", 32'(seen), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    digits_in = 32'h1234_5678;
    dp_in = 8'h00;
    blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hc_en", 32'(hc_en), 32'd0);
    chk("rst_hc_data", 32'(hc_data), 32'h0000_FF00);
    chk("rst_digit_idx", 32'(digit_idx), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    wait_frames(1);
    chk("first_frame", 32'(hc_data), 32'h0000_8001);
    wait_frames(7);
    chk("frame8", 32'(hc_data), 32'h0000_F980);
    chk("frame8_idx", 32'(digit_idx), 32'd7);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      digits_in = (i < 4) ? PAT[i] : $urandom;
      dp_in = (i % 3 == 0) ? 8'h00 : 8'($urandom);
      wait_frames(N);
    end

    // Stall LOAD with RDY held low across two ticks.
    wait_frames(1);
    chk("ovr_before_hold", 32'(overrun), 32'd0);
    repeat (4) @(negedge clk);
    expect_no_ovr = 1'b0;
    hold = 1'b1;
    repeat (25) @(negedge clk);
    chk("ovr_after_hold", 32'(overrun), 32'd1);
    chk("en_while_stalled", 32'(hc_en), 32'd0);
    hold = 1'b0;
    @(negedge clk);
    chk("en_on_rdy_rise", 32'(hc_en), 32'd0);
    @(negedge clk);
    chk("en_after_rdy_rise", 32'(hc_en), 32'd1);

    // Long driver busy time, then reset while waiting for done.
    dly_lo = 20;
    dly_hi = 20;
    wait_frames(1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_hc_en", 32'(hc_en), 32'd0);
    chk("midrst_hc_data", 32'(hc_data), 32'h0000_FF00);
    chk("midrst_digit_idx", 32'(digit_idx), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    dly_lo = 1;
    dly_hi = 4;
    expect_no_ovr = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    wait_frames(1);
    chk("restart_idx", 32'(digit_idx), 32'd0);
    chk("restart_sel", 32'(hc_data[7:0]), 32'h01);

    @(posedge clk);
    #1;
    blank = 1'b1;
    digits_in = $urandom;
    dp_in = 8'hFF;
    wait_frames(N + 1);
    chk("blank_seg", 32'(hc_data[15:8]), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
